// File: rtl/prim_assembler_if.sv
// rtl/prim_assembler_if.sv - decode-side and primitive-side signal bundle for prim_assembler
// Drop_Count exists only when PRIM_ASM_STATS_EN is defined.
interface prim_assembler_if;
  logic        StartPrimitive;
  logic [3:0]  PrimitiveType;
  logic        EndPrimitive;
  logic        Draw;
  logic        NewVertex;
  logic [31:0] Vertex;
  logic        Stall;
  logic [31:0] Prim_V0;
  logic [31:0] Prim_V1;
  logic [31:0] Prim_V2;
  logic [1:0]  Prim_Count;
  logic        Prim_Valid;
  logic        Prim_Ready;
  logic        Frame_Done;
`ifdef PRIM_ASM_STATS_EN
  logic [7:0]  Drop_Count;

  modport master (
    output StartPrimitive, PrimitiveType, EndPrimitive, Draw, NewVertex, Vertex, Prim_Ready,
    input  Stall, Prim_V0, Prim_V1, Prim_V2, Prim_Count, Prim_Valid, Frame_Done, Drop_Count
  );

  modport slave (
    input  StartPrimitive, PrimitiveType, EndPrimitive, Draw, NewVertex, Vertex, Prim_Ready,
    output Stall, Prim_V0, Prim_V1, Prim_V2, Prim_Count, Prim_Valid, Frame_Done, Drop_Count
  );
`else
  modport master (
    output StartPrimitive, PrimitiveType, EndPrimitive, Draw, NewVertex, Vertex, Prim_Ready,
    input  Stall, Prim_V0, Prim_V1, Prim_V2, Prim_Count, Prim_Valid, Frame_Done
  );

  modport slave (
    input  StartPrimitive, PrimitiveType, EndPrimitive, Draw, NewVertex, Vertex, Prim_Ready,
    output Stall, Prim_V0, Prim_V1, Prim_V2, Prim_Count, Prim_Valid, Frame_Done
  );
`endif
endinterface

// File: rtl/prim_assembler.sv
// rtl/prim_assembler.sv - assembles vertex stream into points/lines/triangles with a registered output
// Optional PRIM_ASM_STATS_EN adds a saturating Drop_Count of discarded/ignored vertices.
module prim_assembler (
  input  logic            CLK,
  input  logic            RESET,
  prim_assembler_if.slave bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state, state_next;
  logic [3:0]  ptype;
  logic [1:0]  n, n_next;
  logic        parity;
  logic [31:0] first_v, prev1, prev2;

  logic [31:0] prim_v0, prim_v1, prim_v2;
  logic [1:0]  prim_count;
  logic        prim_valid;
  logic        frame_done;

  logic        stall, accept, type_ok;
  logic        take_end, take_start, take_vertex, take_draw;
  logic        vertex_active, vertex_idle;
  logic        emit;
  logic [31:0] e_v0, e_v1, e_v2;
  logic [1:0]  e_cnt;

  assign stall  = prim_valid & ~bus.Prim_Ready;
  assign accept = ~stall;

  assign bus.Stall      = stall;
  assign bus.Prim_V0    = prim_v0;
  assign bus.Prim_V1    = prim_v1;
  assign bus.Prim_V2    = prim_v2;
  assign bus.Prim_Count = prim_count;
  assign bus.Prim_Valid = prim_valid;
  assign bus.Frame_Done = frame_done;

  // Only one pulse acts per accepted cycle: End > Start > NewVertex > Draw.
  always_comb begin
    take_end      = accept & bus.EndPrimitive;
    take_start    = accept & ~bus.EndPrimitive & bus.StartPrimitive;
    take_vertex   = accept & ~bus.EndPrimitive & ~bus.StartPrimitive & bus.NewVertex;
    take_draw     = accept & ~bus.EndPrimitive & ~bus.StartPrimitive & ~bus.NewVertex & bus.Draw;
    type_ok       = (bus.PrimitiveType <= 4'd5);
    vertex_active = take_vertex & (state == ACTIVE);
    vertex_idle   = take_vertex & (state == IDLE);

    state_next = state;
    if (take_end)
      state_next = IDLE;
    else if (take_start)
      state_next = type_ok ? ACTIVE : IDLE;
    else if (take_draw)
      state_next = IDLE;
  end

  always_comb begin
    emit   = 1'b0;
    e_v0   = '0;
    e_v1   = '0;
    e_v2   = '0;
    e_cnt  = 2'd0;
    n_next = (n == 2'd3) ? n : n + 2'd1;
    if (vertex_active) begin
      case (ptype)
        4'd0: begin
          emit = 1'b1; e_cnt = 2'd1; e_v0 = bus.Vertex;
        end
        4'd1: if (n == 2'd1) begin
          emit = 1'b1; e_cnt = 2'd2; e_v0 = prev1; e_v1 = bus.Vertex; n_next = 2'd0;
        end
        4'd2: if (n != 2'd0) begin
          emit = 1'b1; e_cnt = 2'd2; e_v0 = prev1; e_v1 = bus.Vertex;
        end
        4'd3: if (n == 2'd2) begin
          emit = 1'b1; e_cnt = 2'd3; e_v0 = prev2; e_v1 = prev1; e_v2 = bus.Vertex; n_next = 2'd0;
        end
        // Odd strip triangles swap the two history vertices to keep winding consistent.
        4'd4: if (n >= 2'd2) begin
          emit = 1'b1; e_cnt = 2'd3; e_v2 = bus.Vertex;
          e_v0 = parity ? prev1 : prev2;
          e_v1 = parity ? prev2 : prev1;
        end
        4'd5: if (n >= 2'd2) begin
          emit = 1'b1; e_cnt = 2'd3; e_v0 = first_v; e_v1 = prev1; e_v2 = bus.Vertex;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      ptype      <= 4'd0;
      n          <= 2'd0;
      parity     <= 1'b0;
      first_v    <= '0;
      prev1      <= '0;
      prev2      <= '0;
      prim_v0    <= '0;
      prim_v1    <= '0;
      prim_v2    <= '0;
      prim_count <= 2'd0;
      prim_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (take_end || take_start || take_draw) begin
        n      <= 2'd0;
        parity <= 1'b0;
      end
      if (take_start && type_ok)
        ptype <= bus.PrimitiveType;
      if (vertex_active) begin
        n     <= n_next;
        prev1 <= bus.Vertex;
        prev2 <= prev1;
        if (n == 2'd0)
          first_v <= bus.Vertex;
        if (emit && ptype == 4'd4)
          parity <= ~parity;
      end
      if (accept) begin
        prim_valid <= emit;
        if (emit) begin
          prim_v0    <= e_v0;
          prim_v1    <= e_v1;
          prim_v2    <= e_v2;
          prim_count <= e_cnt;
        end
      end
      frame_done <= take_draw;
    end
  end

`ifdef PRIM_ASM_STATS_EN
  logic [7:0] drop_count;
  logic [1:0] partial;
  logic [1:0] drop_inc;
  logic [8:0] drop_sum;

  // Vertices already consumed by an emitted primitive are not counted as dropped.
  always_comb begin
    partial = 2'd0;
    case (ptype)
      4'd1, 4'd3: partial = n;
      4'd2:       partial = (n == 2'd1) ? 2'd1 : 2'd0;
      4'd4, 4'd5: partial = (n == 2'd3) ? 2'd0 : n;
      default:    partial = 2'd0;
    endcase
    drop_inc = 2'd0;
    if ((take_end || take_start || take_draw) && state == ACTIVE)
      drop_inc = partial;
    else if (vertex_idle)
      drop_inc = 2'd1;
    drop_sum = {1'b0, drop_count} + {7'd0, drop_inc};
  end

  always_ff @(posedge CLK) begin
    if (!RESET)
      drop_count <= 8'd0;
    else
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  assign bus.Drop_Count = drop_count;
`else
  logic unused_idle;
  assign unused_idle = vertex_idle;
`endif

endmodule

// File: tb/tb_prim_assembler.sv
// tb/tb_prim_assembler.sv - scoreboard bench for prim_assembler
// Build with PRIM_ASM_STATS_EN defined to also check Drop_Count.
module tb_prim_assembler;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  prim_assembler_if bus ();

  prim_assembler dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] v0;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [1:0]  cnt;
  } prim_t;

  prim_t       exp_q[$];
  prim_t       mon_e;
  logic [31:0] gv[$];
  int          checks = 0;
  int          errors = 0;
  int          seen   = 0;
  bit          m_active = 0;
  int          m_type   = 0;
  int          exp_drop = 0;

  function automatic void push_exp(logic [31:0] a, logic [31:0] b, logic [31:0] c, logic [1:0] k);
    prim_t p;
    p.v0 = a; p.v1 = b; p.v2 = c; p.cnt = k;
    exp_q.push_back(p);
  endfunction

  function automatic int partial_count();
    int sz = gv.size();
    case (m_type)
      1: return sz % 2;
      3: return sz % 3;
      2: return (sz == 1) ? 1 : 0;
      4, 5: return (sz < 3) ? sz : 0;
      default: return 0;
    endcase
  endfunction

  function automatic void add_drop(int d);
    exp_drop = (exp_drop + d > 255) ? 255 : exp_drop + d;
  endfunction

  function automatic void close_group();
    if (m_active) add_drop(partial_count());
    gv.delete();
    m_active = 0;
  endfunction

  function automatic void model_vertex(logic [31:0] v);
    int k;
    gv.push_back(v);
    k = gv.size() - 1;
    case (m_type)
      0: push_exp(v, 0, 0, 2'd1);
      1: if (k % 2 == 1) push_exp(gv[k-1], v, 0, 2'd2);
      2: if (k >= 1) push_exp(gv[k-1], v, 0, 2'd2);
      3: if (k % 3 == 2) push_exp(gv[k-2], gv[k-1], v, 2'd3);
      4: if (k >= 2) begin
        if ((k - 2) % 2 == 0) push_exp(gv[k-2], gv[k-1], v, 2'd3);
        else                  push_exp(gv[k-1], gv[k-2], v, 2'd3);
      end
      5: if (k >= 2) push_exp(gv[0], gv[k-1], v, 2'd3);
      default: ;
    endcase
  endfunction

  function automatic void model_apply(bit st, logic [3:0] t, bit en, bit dr, bit nv, logic [31:0] v);
    if (en) close_group();
    else if (st) begin
      close_group();
      if (t <= 4'd5) begin m_active = 1; m_type = int'(t); end
    end else if (nv) begin
      if (m_active) model_vertex(v);
      else add_drop(1);
    end else if (dr) close_group();
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    gv.delete();
    m_active = 0;
    m_type   = 0;
    exp_drop = 0;
  endfunction

  task automatic clear_inputs();
    bus.StartPrimitive = 0; bus.PrimitiveType = 0; bus.EndPrimitive = 0;
    bus.Draw = 0; bus.NewVertex = 0; bus.Vertex = 0;
  endtask

  // Drives one command word and holds it until the DUT accepts it.
  task automatic send(bit st, logic [3:0] t, bit en, bit dr, bit nv, logic [31:0] v);
    bit ok = 0;
    bus.StartPrimitive = st; bus.PrimitiveType = t; bus.EndPrimitive = en;
    bus.Draw = dr; bus.NewVertex = nv; bus.Vertex = v;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (bus.Stall === 1'b0) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL stall_timeout Stall=%b required 0 within 100 cycles", bus.Stall);
    end else
      model_apply(st, t, en, dr, nv, v);
    @(posedge CLK); #1;
    clear_inputs();
  endtask

  task automatic start(logic [3:0] t);  send(1, t, 0, 0, 0, 0); endtask
  task automatic vert(logic [31:0] v);  send(0, 0, 0, 0, 1, v); endtask
  task automatic endp();                send(0, 0, 1, 0, 0, 0); endtask
  task automatic idle(int c);           repeat (c) @(posedge CLK); #1; endtask

  always @(negedge CLK) begin
    if (RESET === 1'b1 && bus.Prim_Valid === 1'b1 && bus.Prim_Ready === 1'b1) begin
      seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_prim got V0=%h V1=%h V2=%h Count=%0d required none",
                 bus.Prim_V0, bus.Prim_V1, bus.Prim_V2, bus.Prim_Count);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.Prim_V0 !== mon_e.v0 || bus.Prim_V1 !== mon_e.v1 ||
            bus.Prim_V2 !== mon_e.v2 || bus.Prim_Count !== mon_e.cnt) begin
          errors++;
          $display("FAIL prim got %h %h %h cnt=%0d required %h %h %h cnt=%0d",
                   bus.Prim_V0, bus.Prim_V1, bus.Prim_V2, bus.Prim_Count,
                   mon_e.v0, mon_e.v1, mon_e.v2, mon_e.cnt);
        end
      end
    end
  end

  task automatic check_seen(string name, int base, int want);
    checks++;
    if (seen - base !== want) begin
      errors++;
      $display("FAIL %s primitives got %0d required %0d", name, seen - base, want);
    end
  endtask

  task automatic check_drop(string name);
`ifdef PRIM_ASM_STATS_EN
    checks++;
    if (bus.Drop_Count !== 8'(exp_drop)) begin
      errors++;
      $display("FAIL %s Drop_Count got %0d required %0d", name, bus.Drop_Count, exp_drop);
    end
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.Prim_Ready = 1;
    RESET = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (bus.Prim_Valid !== 1'b0 || bus.Stall !== 1'b0 || bus.Frame_Done !== 1'b0 ||
        bus.Prim_Count !== 2'd0 || bus.Prim_V0 !== 32'd0 || bus.Prim_V1 !== 32'd0 ||
        bus.Prim_V2 !== 32'd0) begin
      errors++;
      $display("FAIL reset_state got valid=%b stall=%b fd=%b cnt=%0d v0=%h required all 0",
               bus.Prim_Valid, bus.Stall, bus.Frame_Done, bus.Prim_Count, bus.Prim_V0);
    end
    check_drop("reset");
    @(posedge CLK); #1;
    RESET = 1;
    model_reset();
  endtask

  task automatic test_triangles();
    int base = seen;
    start(3);
    vert(32'h0001_0001); vert(32'h0002_0002); vert(32'h0003_0003);
    endp();
    idle(3);
    check_seen("triangles", base, 1);
  endtask

  task automatic test_tri_strip();
    int base = seen;
    start(4);
    vert(32'hAAAA_0001); vert(32'hBBBB_0002); vert(32'hCCCC_0003); vert(32'hDDDD_0004);
    endp();
    idle(3);
    check_seen("tri_strip", base, 2);
  endtask

  task automatic test_all_types();
    int want[6] = '{5, 2, 4, 1, 3, 3};
    for (int t = 0; t < 6; t++) begin
      int base = seen;
      start(4'(t));
      for (int i = 0; i < 5; i++) vert($urandom);
      endp();
      idle(3);
      check_seen($sformatf("type%0d", t), base, want[t]);
    end
    check_drop("all_types");
  endtask

  task automatic test_back_pressure();
    int base = seen;
    bus.Prim_Ready = 0;
    start(0);
    vert(32'h1111_1111);
    bus.NewVertex = 1; bus.Vertex = 32'h2222_2222;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (bus.Stall !== 1'b1 || bus.Prim_Valid !== 1'b1 || bus.Prim_V0 !== 32'h1111_1111 ||
          bus.Prim_Count !== 2'd1) begin
        errors++;
        $display("FAIL bp_hold got stall=%b valid=%b v0=%h cnt=%0d required 1 1 11111111 1",
                 bus.Stall, bus.Prim_Valid, bus.Prim_V0, bus.Prim_Count);
      end
    end
    @(posedge CLK); #1;
    bus.Prim_Ready = 1;
    @(negedge CLK);
    checks++;
    if (bus.Stall !== 1'b0) begin
      errors++;
      $display("FAIL bp_release Stall got %b required 0", bus.Stall);
    end
    model_apply(0, 0, 0, 0, 1, 32'h2222_2222);
    @(posedge CLK); #1;
    clear_inputs();
    endp();
    idle(3);
    check_seen("back_pressure", base, 2);
  endtask

  task automatic test_back_to_back();
    int base = seen;
    start(0);
    for (int i = 0; i < 6; i++) begin
      vert(32'h5000_0000 + 32'(i));
      if (i > 0) begin
        @(negedge CLK);
        checks++;
        if (bus.Prim_Valid !== 1'b1) begin
          errors++;
          $display("FAIL b2b_valid cycle %0d got %b required 1", i, bus.Prim_Valid);
        end
        @(posedge CLK); #1;
        vert(32'h6000_0000 + 32'(i));
      end
    end
    endp();
    idle(3);
    check_seen("back_to_back", base, 11);
  endtask

  task automatic test_partial_drop();
    int base = seen;
    start(1);
    vert(32'h0BAD_0001);
    endp();
    idle(3);
    check_seen("partial_drop", base, 0);
    check_drop("partial_drop");
  endtask

  task automatic test_reset_mid();
    int base;
    start(5);
    vert(32'hDEAD_0001); vert(32'hDEAD_0002);
    RESET = 0; @(posedge CLK); #1; RESET = 1;
    model_reset();
    bus.Prim_Ready = 0;
    start(0);
    vert(32'hDEAD_0003);
    RESET = 0; @(posedge CLK); #1; RESET = 1;
    model_reset();
    @(negedge CLK);
    checks++;
    if (bus.Prim_Valid !== 1'b0 || bus.Stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_flush got valid=%b stall=%b required 0 0", bus.Prim_Valid, bus.Stall);
    end
    check_drop("reset_mid");
    @(posedge CLK); #1;
    bus.Prim_Ready = 1;
    base = seen;
    start(5);
    vert(32'hF00D_0001); vert(32'hF00D_0002); vert(32'hF00D_0003);
    endp();
    idle(3);
    check_seen("reset_mid_fan", base, 1);
  endtask

  task automatic draw_check(string name);
    bus.Draw = 1;
    @(negedge CLK);
    checks++;
    if (bus.Stall !== 1'b0 || bus.Frame_Done !== 1'b0) begin
      errors++;
      $display("FAIL %s_pre got stall=%b fd=%b required 0 0", name, bus.Stall, bus.Frame_Done);
    end
    model_apply(0, 0, 0, 1, 0, 0);
    @(posedge CLK); #1;
    bus.Draw = 0;
    @(negedge CLK);
    checks++;
    if (bus.Frame_Done !== 1'b1) begin
      errors++;
      $display("FAIL %s_pulse Frame_Done got %b required 1", name, bus.Frame_Done);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if (bus.Frame_Done !== 1'b0) begin
      errors++;
      $display("FAIL %s_end Frame_Done got %b required 0", name, bus.Frame_Done);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_draw();
    int base;
    start(3);
    vert(32'h0101_0101); vert(32'h0202_0202); vert(32'h0303_0303);
    endp();
    draw_check("draw_idle");
    base = seen;
    start(3);
    vert(32'h0404_0404); vert(32'h0505_0505);
    draw_check("draw_active");
    vert(32'h0606_0606);
    idle(3);
    check_seen("draw_closes", base, 0);
    check_drop("draw");
  endtask

  task automatic test_priority();
    int base = seen;
    start(2);
    vert(32'h7000_0001);
    send(1, 0, 1, 0, 1, 32'h7000_0002);
    vert(32'h7000_0003);
    send(1, 0, 0, 0, 1, 32'h7000_0004);
    vert(32'h7000_0005);
    send(0, 0, 0, 1, 1, 32'h7000_0006);
    @(negedge CLK);
    checks++;
    if (bus.Frame_Done !== 1'b0) begin
      errors++;
      $display("FAIL prio_draw_masked Frame_Done got %b required 0", bus.Frame_Done);
    end
    @(posedge CLK); #1;
    start(4'd9);
    vert(32'h7000_0007);
    idle(3);
    check_seen("priority", base, 2);
    check_drop("priority");
  endtask

  task automatic test_final();
    idle(5);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d required 0", exp_q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_triangles();
    test_tri_strip();
    test_all_types();
    test_back_pressure();
    test_back_to_back();
    test_partial_drop();
    test_draw();
    test_priority();
    test_reset_mid();
    test_final();
    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule

// File: doc/prim_assembler.md
PRIM_ASSEMBLER -- requirements
Module: prim_assembler

Interface
REQ-001 SHALL have port CLK  input  1  sole clock; all state updates on posedge.
REQ-002 SHALL have port RESET  input  1  synchronous, active-low reset (sampled on posedge CLK; 0 = reset).
REQ-003 SHALL have port StartPrimitive  input  1  one-cycle pulse from decode: begin primitive group.
REQ-004 SHALL have port PrimitiveType  input  4  group type, valid with StartPrimitive: 0 points, 1 lines, 2 line strip, 3 triangles, 4 triangle strip, 5 triangle fan, 6-15 invalid.
REQ-005 SHALL have port EndPrimitive  input  1  one-cycle pulse: close current group.
REQ-006 SHALL have port Draw  input  1  one-cycle pulse: frame flush request.
REQ-007 SHALL have port NewVertex  input  1  Vertex is valid this cycle.
REQ-008 SHALL have port Vertex  input  32  X=[15:0], Y=[31:16].
REQ-009 SHALL have port Stall  output  1  back-pressure to decode; decode holds its outputs while high.
REQ-010 SHALL have ports Prim_V0, Prim_V1, Prim_V2  output  32 each  assembled primitive vertices.
REQ-011 SHALL have port Prim_Count  output  2  vertices used: 1 point, 2 line, 3 triangle.
REQ-012 SHALL have port Prim_Valid  output  1  primitive on Prim_* is valid; port Prim_Ready  input  1  consumer accepts.
REQ-013 SHALL have port Frame_Done  output  1  one-cycle pulse on completed Draw.

Function
REQ-014 SHALL implement FSM states IDLE and ACTIVE; StartPrimitive with valid type -> ACTIVE, latch type, clear vertex index n; invalid type -> stay/return to IDLE.
REQ-015 SHALL, in ACTIVE, on NewVertex with Stall low, store Vertex into a 3-entry history buffer and increment n (saturating at 3; strip parity tracked separately, wrapping).
REQ-016 SHALL emit primitives: points every vertex; lines on every 2nd vertex (V0,V1); line strip per vertex from n>=2 (prev, cur); triangles on every 3rd vertex; triangle strip from n>=3 as (v[n-2],v[n-1],v[n]) on even parity, (v[n-1],v[n-2],v[n]) on odd; fan from n>=3 as (first, prev, cur).
REQ-017 SHALL register the emitted primitive so Prim_Valid rises the cycle after the completing vertex (latency 1); unused Prim_V* outputs SHALL be 0.
REQ-018 SHALL hold Prim_V*, Prim_Count, Prim_Valid stable while Prim_Valid=1 and Prim_Ready=0.
REQ-019 SHALL drive Stall = Prim_Valid & ~Prim_Ready (combinational); all inputs are ignored while Stall=1.
REQ-020 SHALL sustain one primitive per cycle: when Prim_Valid&Prim_Ready and a new primitive completes the same cycle, Prim_Valid stays 1 with new data.
REQ-021 SHALL, on EndPrimitive, go to IDLE and discard incomplete partial vertices.
REQ-022 SHALL treat StartPrimitive in ACTIVE as restart: discard partial, latch new type.
REQ-023 SHALL ignore NewVertex in IDLE.
REQ-024 SHALL pulse Frame_Done one cycle after Draw is accepted (Stall low); Draw in ACTIVE also closes the group as EndPrimitive.
REQ-025 SHALL apply priority EndPrimitive > StartPrimitive > NewVertex > Draw if several pulses coincide.

Reset
REQ-026 SHALL, while RESET=0 at posedge, force IDLE, n=0, parity=0, type=0, history cleared, Prim_Valid=0, Prim_V*=0, Prim_Count=0, Frame_Done=0; Stall therefore 0.
REQ-027 SHALL abandon any in-flight primitive (including unaccepted Prim_Valid) on reset mid-operation.

Configuration
REQ-028 SHALL, when PRIM_ASM_STATS_EN is defined, add output Drop_Count (8 bits, reset 0) counting vertices discarded by REQ-021/022/024 and NewVertex ignored in IDLE, saturating at 255; without the macro the port and counter SHALL not exist and behaviour is otherwise identical.

Verification
REQ-029 Triangles: Start type 3, vertices 0x00010001,0x00020002,0x00030003, Ready=1 -> one Prim_Valid cycle, Count=3, V0..V2 in order.
REQ-030 Triangle strip: type 4, vertices A,B,C,D -> primitives (A,B,C) then (C,B,D).
REQ-031 Back-pressure: type 0, Ready=0, two vertices -> Stall=1 after first, second held; Ready=1 -> both points delivered, none lost.
REQ-032 Partial drop: type 1, one vertex, EndPrimitive -> no Prim_Valid; with PRIM_ASM_STATS_EN Drop_Count=1.
REQ-033 Reset mid-primitive: type 5, two vertices, RESET=0 one cycle, then type 5 with 3 vertices -> single fan with new vertices only.
REQ-034 Draw: after EndPrimitive, Draw pulse -> Frame_Done=1 exactly one cycle later.
